xs3_bcd_seq_converter: RTL



---
 rtl/xs3_bcd_seq_converter_if.sv | 25 ++
 rtl/xs3_bcd_seq_converter.sv | 93 +++++++++
 2 files changed

// File: rtl/xs3_bcd_seq_converter_if.sv
// Handshake bundle for the excess-3 / BCD sequential converter.
// The converter uses the slave side; the producer/consumer uses the master side.
interface xs3_bcd_seq_converter_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_mode;
   logic [4*DIGITS-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_data;
   logic [DIGITS-1:0]     out_err_mask;
   logic                  out_err;

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err_mask, out_err
   );

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err_mask, out_err
   );
endinterface

// File: rtl/xs3_bcd_seq_converter.sv
// Digit-serial excess-3 <-> BCD converter: one digit per clock, LSB digit first,
// with a per-digit illegal-code mask and a held result until downstream accepts it.
module xs3_bcd_seq_converter #(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   xs3_bcd_seq_converter_if.slave    bus
);
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [IDXW-1:0]       r_idx;
   logic [4*DIGITS-1:0]   r_inData;
   logic [4*DIGITS-1:0]   r_outData;
   logic [DIGITS-1:0]     r_errMask;
   logic                  r_mode;

   logic [3:0]            w_digit;
   logic [3:0]            w_conv;
   logic                  w_illegal;

   // Mode 1 expects BCD (0..9), mode 0 expects excess-3 (3..12); bad codes become F.
   always_comb begin
      w_digit   = r_inData[4*r_idx +: 4];
      w_conv    = 4'h0;
      w_illegal = 1'b0;
      if (r_mode) begin
         w_illegal = (w_digit > 4'd9);
         w_conv    = w_digit + 4'd3;
      end else begin
         w_illegal = (w_digit < 4'd3) || (w_digit > 4'd12);
         w_conv    = w_digit - 4'd3;
      end
      if (w_illegal) begin
         w_conv = 4'hF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_inData  <= '0;
         r_outData <= '0;
         r_errMask <= '0;
         r_mode    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_inData  <= bus.in_data;
                  r_mode    <= bus.in_mode;
                  r_errMask <= '0;
                  r_idx     <= '0;
                  r_state   <= CONV;
               end
            end
            CONV: begin
               r_outData[4*r_idx +: 4] <= w_conv;
               r_errMask[r_idx]        <= w_illegal;
               if (r_idx == LAST_IDX) begin
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Ready is gated by rst_n so no word can be taken while reset is held.
   assign bus.in_ready     = (r_state == IDLE) && rst_n;
   assign bus.out_valid    = (r_state == DONE);
   assign bus.out_data     = r_outData;
   assign bus.out_err_mask = r_errMask;
   assign bus.out_err      = |r_errMask;
endmodule
